video_fb: RTL and testbench
===========================

VIDEO_FB -- requirements
Module: video_fb

Interface
REQ-001 SHALL have parameter WIDTH, default 320, meaning pixels per line of the framebuffer.
REQ-002 SHALL have parameter HEIGHT, default 240, meaning lines per frame.
REQ-003 SHALL have ports clock25mhz input 1 (sole clock) and resetn input 1; one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports x input 12 and y input 12, meaning the pixel coordinate requested by the display stage.
REQ-005 SHALL have ports r output 8, g output 8 and b output 8, meaning the colour for the requested pixel.
REQ-006 SHALL have write-port signals: wr_valid input 1, wr_ready output 1, wr_addr input 17 (linear pixel index), wr_data input 4 (palette index).
REQ-007 SHALL have palette-port signals: pal_we input 1, pal_idx input 4, pal_rgb input 24 ({r,g,b}).
REQ-008 SHALL have clear-port signals: clr_start input 1 (pulse), clr_color input 4, busy output 1.
REQ-009 SHALL have port frame_tick output 1, a one-cycle frame-start pulse.

Function
REQ-010 SHALL compute read address y*WIDTH+x, registered in cycle 1, using shift/add for the default geometry (y<<8 + y<<6 + x).
REQ-011 SHALL read the 4-bit index from RAM with a registered read in cycle 2, then register the palette lookup onto {r,g,b}; total latency is exactly 2 cycles from x/y to r/g/b (display stage uses CYCLE_DELAY=2).
REQ-012 SHALL treat x>=WIDTH or y>=HEIGHT as out of range and output {r,g,b}=0 for it, with the same latency.
REQ-013 SHALL accept a write on a cycle where wr_valid&&wr_ready, storing wr_data at wr_addr; the stored pixel is visible to reads starting the following cycle.
REQ-014 SHALL drop, without stalling, a handshaken write whose wr_addr>=WIDTH*HEIGHT.
REQ-015 SHALL drive wr_ready=1 in IDLE and wr_ready=0 in CLEAR.
REQ-016 SHALL implement the state machine IDLE->CLEAR on clr_start in IDLE, and CLEAR->IDLE after the write to address WIDTH*HEIGHT-1.
REQ-017 SHALL, in CLEAR, write clr_color (latched at entry) to one address per cycle, ascending from 0, for WIDTH*HEIGHT cycles; busy=1 exactly while in CLEAR.
REQ-018 SHALL ignore clr_start while in CLEAR.
REQ-019 SHALL, when wr_valid and clr_start are both high in IDLE, accept the write, then enter CLEAR the next cycle, so the clear overwrites the written pixel.
REQ-020 SHALL pulse frame_tick for one cycle when registered previous (x,y)==(WIDTH-1,HEIGHT-1) and current (x,y)==(0,0).
REQ-021 SHALL continue display reads during CLEAR, returning a mix of old and cleared data; this is not an error.

Reset
REQ-022 SHALL, while resetn=0 at a clock edge, set r=g=b=0, wr_ready=0, busy=0, frame_tick=0, state=IDLE, clear counter=0 and the previous-coordinate registers=0.
REQ-023 SHALL reset palette entry i (active and shadow) to r=g=b={i,i}, i.e. 0x00,0x11..0xFF greyscale.
REQ-024 SHALL NOT reset framebuffer RAM contents; a reset during CLEAR abandons the clear, leaving partially cleared memory.

Configuration
REQ-025 SHALL, with VIDEO_FB_PAL_SHADOW_EN defined, route pal_we into a shadow palette and copy shadow to active on the cycle frame_tick is asserted; a pal_we on that same cycle lands in the shadow only and commits at the next frame.
REQ-026 SHALL, without VIDEO_FB_PAL_SHADOW_EN, write pal_we directly into the active palette, with the new colour appearing on r/g/b for lookups registered after the write cycle; no shadow storage is built.

Structure
REQ-027 SHALL place FB_BPP=4, FB_ADDR_W=17, PAL_ENTRIES=16 and the IDLE/CLEAR state enum in package video_fb_pkg.
REQ-028 SHALL instantiate one sub-module, fb_ram_dp: simple dual-port RAM with 1 write port and 1 registered read port, depth WIDTH*HEIGHT x FB_BPP.

Verification
REQ-029 SHALL check: write idx 5 to addr 321, palette[5]=0x123456, drive x=1,y=1 -> {r,g,b}=0x123456 exactly 2 cycles later.
REQ-030 SHALL check: x=320,y=0 or x=0,y=240 -> {r,g,b}=0 at 2 cycles; a write to addr 76800 is accepted and leaves memory unchanged.
REQ-031 SHALL check: clr_start with clr_color=3 -> busy=1 for 76800 cycles, wr_ready=0 throughout, then random reads return palette[3]; a second clr_start mid-clear is ignored.
REQ-032 SHALL check: wr_valid+clr_start in the same cycle -> write handshaken, addr later reads clr_color.
REQ-033 SHALL check: with the macro defined, a pal_we mid-frame is invisible until the (319,239)->(0,0) transition, then visible at the next lookup; without the macro it is visible immediately.
REQ-034 SHALL check: resetn low for 1 cycle mid-CLEAR -> busy=0, wr_ready=0 during reset then 1, palette back to greyscale.

Source files
------------

// File: rtl/video_fb_pkg.sv
// video_fb_pkg: shared constants, controller state type and palette reset
// helper for the video framebuffer.
//   FB_BPP       bits per stored pixel (palette index width)
//   FB_ADDR_W    width of a linear pixel address
//   PAL_ENTRIES  number of palette entries
package video_fb_pkg;

    localparam int FB_BPP      = 4;
    localparam int FB_ADDR_W   = 17;
    localparam int PAL_ENTRIES = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // Greyscale reset colour: entry i becomes {i,i} on each of r, g and b.
    function automatic logic [23:0] pal_grey(input logic [3:0] idx);
        return {idx, idx, idx, idx, idx, idx};
    endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// fb_ram_dp: simple dual-port RAM, one write port and one registered read
// port, no reset on contents.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   raddr_i          read address, captured every cycle
//   rdata_o          registered read data (one cycle latency)
module fb_ram_dp #(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port (read-before-write on an address collision).
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_fb.sv
// video_fb: palettised framebuffer with a display read path, a pixel write
// port, a bulk clear engine and a 16-entry palette.
//   clock25mhz, resetn        clock and synchronous active-low reset
//   x, y                      display pixel coordinate in
//   r, g, b                   colour out, two cycles after x/y
//   wr_valid/wr_ready/wr_addr/wr_data   pixel write handshake
//   pal_we/pal_idx/pal_rgb    palette write
//   clr_start/clr_color/busy  whole-frame clear
//   frame_tick                one-cycle pulse after (W-1,H-1)->(0,0)
// Optional build macro VIDEO_FB_PAL_SHADOW_EN: palette writes go to a shadow
// copy that is committed to the active palette once per frame.
module video_fb
    import video_fb_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                 clock25mhz,
    input  logic                 resetn,
    input  logic [11:0]          x,
    input  logic [11:0]          y,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [FB_BPP-1:0]    wr_data,
    input  logic                 pal_we,
    input  logic [3:0]           pal_idx,
    input  logic [23:0]          pal_rgb,
    input  logic                 clr_start,
    input  logic [FB_BPP-1:0]    clr_color,
    output logic                 busy,
    output logic                 frame_tick
);

    localparam int                   NPIX      = WIDTH * HEIGHT;
    localparam logic [FB_ADDR_W-1:0] NPIX_A    = FB_ADDR_W'(NPIX);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NPIX - 1);
    localparam logic [11:0]          X_LAST    = 12'(WIDTH - 1);
    localparam logic [11:0]          Y_LAST    = 12'(HEIGHT - 1);

    fb_state_e             state_q, state_d;
    logic [FB_ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [FB_BPP-1:0]     clr_color_q, clr_color_d;
    logic                  wr_ready_q, busy_q, frame_tick_q, in_range_q;
    logic [11:0]           prev_x_q, prev_y_q;
    logic [23:0]           rgb_q;
    logic [23:0]           pal_q [PAL_ENTRIES];
`ifdef VIDEO_FB_PAL_SHADOW_EN
    logic [23:0]           shadow_q [PAL_ENTRIES];
`endif

    logic                  in_range_s, wr_fire_s, ram_we_s;
    logic [FB_ADDR_W-1:0]  rd_addr_s, ram_waddr_s;
    logic [FB_BPP-1:0]     ram_wdata_s, ram_rdata_s;

    // Display address y*WIDTH+x; the RAM read register captures it in cycle 1.
    always_comb begin
        in_range_s = (x < 12'(WIDTH)) && (y < 12'(HEIGHT));
        rd_addr_s  = '0;
        if (!in_range_s) begin
            rd_addr_s = '0;
        end else if (WIDTH == 320) begin
            rd_addr_s = FB_ADDR_W'(({12'd0, y} << 8) + ({12'd0, y} << 6) + {12'd0, x});
        end else begin
            rd_addr_s = FB_ADDR_W'(({12'd0, y} * 24'(WIDTH)) + {12'd0, x});
        end
    end

    // Controller next state and RAM write-port steering.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        wr_fire_s   = wr_valid && wr_ready_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_addr;
        ram_wdata_s = wr_data;
        case (state_q)
            IDLE: begin
                // Out-of-range writes complete the handshake but are dropped.
                if (wr_fire_s && (wr_addr < NPIX_A)) begin
                    ram_we_s = 1'b1;
                end else begin
                    ram_we_s = 1'b0;
                end
                if (clr_start) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    clr_color_d = clr_color;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_cnt_q;
                ram_wdata_s = clr_color_q;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Controller, frame-tick and colour-output registers.
    always_ff @(posedge clock25mhz) begin
        if (!resetn) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            clr_color_q  <= '0;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            prev_x_q     <= 12'd0;
            prev_y_q     <= 12'd0;
            frame_tick_q <= 1'b0;
            in_range_q   <= 1'b0;
            rgb_q        <= 24'd0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_color_q  <= clr_color_d;
            wr_ready_q   <= (state_d == IDLE);
            busy_q       <= (state_d == CLEAR);
            prev_x_q     <= x;
            prev_y_q     <= y;
            frame_tick_q <= (prev_x_q == X_LAST) && (prev_y_q == Y_LAST) &&
                            (x == 12'd0) && (y == 12'd0);
            in_range_q   <= in_range_s;
            if (in_range_q) begin
                rgb_q <= pal_q[ram_rdata_s];
            end else begin
                rgb_q <= 24'd0;
            end
        end
    end

    // Palette storage; with the shadow build the commit on frame_tick uses the
    // shadow contents from before any same-cycle palette write.
    always_ff @(posedge clock25mhz) begin
        if (!resetn) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal_q[i] <= pal_grey(4'(i));
`ifdef VIDEO_FB_PAL_SHADOW_EN
                shadow_q[i] <= pal_grey(4'(i));
`endif
            end
        end else begin
`ifdef VIDEO_FB_PAL_SHADOW_EN
            if (frame_tick_q) begin
                pal_q <= shadow_q;
            end
            if (pal_we) begin
                shadow_q[pal_idx] <= pal_rgb;
            end
`else
            if (pal_we) begin
                pal_q[pal_idx] <= pal_rgb;
            end
`endif
        end
    end

    fb_ram_dp #(
        .DEPTH  (NPIX),
        .ADDR_W (FB_ADDR_W),
        .DATA_W (FB_BPP)
    ) u_ram (
        .clk_i   (clock25mhz),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    assign r          = rgb_q[23:16];
    assign g          = rgb_q[15:8];
    assign b          = rgb_q[7:0];
    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_video_fb.sv
// tb_video_fb: directed self-checking bench for video_fb (default geometry).
module tb_video_fb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] x, y;
    logic [7:0]  r, g, b;
    logic        wr_valid, wr_ready;
    logic [16:0] wr_addr;
    logic [3:0]  wr_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_rgb;
    logic        clr_start;
    logic [3:0]  clr_color;
    logic        busy, frame_tick;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    video_fb dut (
        .clock25mhz (clk),
        .resetn     (resetn),
        .x          (x),
        .y          (y),
        .r          (r),
        .g          (g),
        .b          (b),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_rgb    (pal_rgb),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    // Called at a negedge: present x/y, return the colour two cycles later.
    task automatic read_px(input logic [11:0] px, input logic [11:0] py, output logic [23:0] got);
        x = px;
        y = py;
        @(negedge clk);
        @(negedge clk);
        got = {r, g, b};
    endtask

    // Called at a negedge: one-cycle write request, returns wr_ready seen.
    task automatic write_px(input logic [16:0] a, input logic [3:0] d, output logic rdy);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        rdy      = wr_ready;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write_pal(input logic [3:0] i, input logic [23:0] c);
        pal_we  = 1'b1;
        pal_idx = i;
        pal_rgb = c;
        @(negedge clk);
        pal_we  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", {r, g, b}); end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b expected 0", frame_tick); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_basic_read();
        logic rdy;
        write_px(17'd321, 4'd5, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wr_321_ready: got %b expected 1", rdy); end
        write_pal(4'd5, 24'h123456);
        x = 12'd320; y = 12'd0;
        @(negedge clk);
        @(negedge clk);
        // Stream (1,1), (320,0), (0,240) on consecutive cycles.
        x = 12'd1; y = 12'd1;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL latency_early: got %h expected 000000", {r, g, b}); end
        x = 12'd320; y = 12'd0;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 24'h123456) begin errors++; $display("FAIL px_1_1: got %h expected 123456", {r, g, b}); end
        x = 12'd0; y = 12'd240;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL oor_x320: got %h expected 000000", {r, g, b}); end
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL oor_y240: got %h expected 000000", {r, g, b}); end
    endtask

    task automatic test_out_of_range();
        logic rdy;
        logic [23:0] got;
        write_px(17'd76800, 4'd10, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wr_76800_ready: got %b expected 1", rdy); end
        read_px(12'd1, 12'd1, got);
        checks++;
        if (got !== 24'h123456) begin errors++; $display("FAIL oor_write_no_effect: got %h expected 123456", got); end
        write_px(17'd76799, 4'd5, rdy);
        read_px(12'd319, 12'd239, got);
        checks++;
        if (got !== 24'h123456) begin errors++; $display("FAIL px_last: got %h expected 123456", got); end
        read_px(12'd4095, 12'd4095, got);
        checks++;
        if (got !== 24'h000000) begin errors++; $display("FAIL oor_max: got %h expected 000000", got); end
    endtask

    task automatic test_palette();
        logic [23:0] got;
        logic [23:0] exp_before;
`ifdef VIDEO_FB_PAL_SHADOW_EN
        exp_before = 24'h123456;
`else
        exp_before = 24'hABCDEF;
`endif
        write_pal(4'd5, 24'hABCDEF);
        read_px(12'd1, 12'd1, got);
        checks++;
        if (got !== exp_before) begin errors++; $display("FAIL pal_mid_frame: got %h expected %h", got, exp_before); end
        // (319,239) -> (1,0) is not a frame start.
        x = 12'd319; y = 12'd239;
        @(negedge clk);
        x = 12'd1; y = 12'd0;
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_false: got %b expected 0", frame_tick); end
        x = 12'd319; y = 12'd239;
        @(negedge clk);
        x = 12'd0; y = 12'd0;
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL tick_pulse: got %b expected 1", frame_tick); end
        @(negedge clk);
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_one_cycle: got %b expected 0", frame_tick); end
        read_px(12'd1, 12'd1, got);
        checks++;
        if (got !== 24'hABCDEF) begin errors++; $display("FAIL pal_after_frame: got %h expected ABCDEF", got); end
    endtask

    task automatic test_clear_back_to_back();
        logic rdy;
        logic [23:0] got;
        int cnt;
        int viol;
        // Write to (2,2) and start a clear in the same cycle.
        wr_valid  = 1'b1;
        wr_addr   = 17'd642;
        wr_data   = 4'd9;
        clr_start = 1'b1;
        clr_color = 4'd3;
        rdy       = wr_ready;
        @(negedge clk);
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        clr_color = 4'd7;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wr_with_clr_ready: got %b expected 1", rdy); end
        cnt  = 0;
        viol = 0;
        while (busy === 1'b1 && cnt < 80000) begin
            if (wr_ready !== 1'b0) viol++;
            cnt++;
            if (cnt == 100) clr_start = 1'b1;
            else clr_start = 1'b0;
            @(negedge clk);
        end
        clr_start = 1'b0;
        checks++;
        if (cnt != 76800) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 76800", cnt); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL clr_wr_ready_low: got %0d high cycles expected 0", viol); end
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL clr_done: got busy=%b wr_ready=%b expected busy=0 wr_ready=1", busy, wr_ready); end
        read_px(12'd2, 12'd2, got);
        checks++;
        if (got !== 24'h333333) begin errors++; $display("FAIL clr_px_2_2: got %h expected 333333", got); end
        read_px(12'd0, 12'd0, got);
        checks++;
        if (got !== 24'h333333) begin errors++; $display("FAIL clr_px_0_0: got %h expected 333333", got); end
        read_px(12'd319, 12'd239, got);
        checks++;
        if (got !== 24'h333333) begin errors++; $display("FAIL clr_px_last: got %h expected 333333", got); end
        read_px(12'd160, 12'd120, got);
        checks++;
        if (got !== 24'h333333) begin errors++; $display("FAIL clr_px_mid: got %h expected 333333", got); end
    endtask

    task automatic test_reset_mid_clear();
        logic rdy;
        logic [23:0] got;
        clr_start = 1'b1;
        clr_color = 4'd1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_clr_busy: got %b expected 1", busy); end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rst_clr_in_reset: got busy=%b wr_ready=%b expected 0 0", busy, wr_ready); end
        checks++;
        if ({r, g, b} !== 24'h000000) begin errors++; $display("FAIL rst_clr_rgb: got %h expected 000000", {r, g, b}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL rst_clr_after: got busy=%b wr_ready=%b expected 0 1", busy, wr_ready); end
        read_px(12'd0, 12'd0, got);
        checks++;
        if (got !== 24'h111111) begin errors++; $display("FAIL rst_clr_px0: got %h expected 111111", got); end
        read_px(12'd2, 12'd2, got);
        checks++;
        if (got !== 24'h333333) begin errors++; $display("FAIL rst_clr_abandoned: got %h expected 333333", got); end
        write_px(17'd500, 4'd2, rdy);
        read_px(12'd180, 12'd1, got);
        checks++;
        if (got !== 24'h222222) begin errors++; $display("FAIL rst_pal2_grey: got %h expected 222222", got); end
        write_px(17'd76799, 4'd5, rdy);
        read_px(12'd319, 12'd239, got);
        checks++;
        if (got !== 24'h555555) begin errors++; $display("FAIL rst_pal5_grey: got %h expected 555555", got); end
    endtask

    initial begin
        resetn    = 1'b0;
        x         = 12'd320;
        y         = 12'd0;
        wr_valid  = 1'b0;
        wr_addr   = 17'd0;
        wr_data   = 4'd0;
        pal_we    = 1'b0;
        pal_idx   = 4'd0;
        pal_rgb   = 24'd0;
        clr_start = 1'b0;
        clr_color = 4'd0;
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_out_of_range();
        test_palette();
        test_clear_back_to_back();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
